// File: rtl/unishreg_seq.sv
// unishreg_seq: WIDTH-bit universal shift register with a start/busy/done sequencer running multi-bit shifts one bit per clock.
// Defining USR_CARRY_EN adds a carry output holding the last bit shifted out.
module unishreg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic             sin_left,
  input  logic             sin_right,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_left,
  output logic             sout_right,
  output logic             busy,
`ifdef USR_CARRY_EN
  output logic             carry,
`endif
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [2:0] SRL = 3'b001, SLL = 3'b010, LOAD = 3'b011, ROR = 3'b100, ROL = 3'b101, SRA = 3'b110;
  state_t state, state_n;
  logic [2:0] op_r, op_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] q_n, step;
  logic is_shift;
  assign is_shift = op == SRL || op == SLL || op == ROR || op == ROL || op == SRA;
  assign sout_left = q[WIDTH-1];
  assign sout_right = q[0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    step = q;
    case (op_r)
      SRL:     step = {sin_right, q[WIDTH-1:1]};
      SLL:     step = {q[WIDTH-2:0], sin_left};
      ROR:     step = {q[0], q[WIDTH-1:1]};
      ROL:     step = {q[WIDTH-2:0], q[WIDTH-1]};
      SRA:     step = {q[WIDTH-1], q[WIDTH-1:1]};
      default: step = q;
    endcase
  end
  always_comb begin
    state_n = state;
    q_n = q;
    op_n = op_r;
    cnt_n = cnt;
    case (state)
      IDLE: if (start) begin
        state_n = (is_shift && amount != '0) ? SHIFT : DONE;
        op_n = op;
        cnt_n = amount;
        q_n = (op == LOAD) ? d : q;
      end
      SHIFT: begin
        q_n = step;
        cnt_n = cnt - CNT_W'(1);
        state_n = (cnt == CNT_W'(1)) ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q <= '0;
      op_r <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      q <= q_n;
      op_r <= op_n;
      cnt <= cnt_n;
    end
  end
`ifdef USR_CARRY_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start && op == LOAD))
      carry <= 1'b0;
    else if (state == SHIFT)
      carry <= (op_r == SLL || op_r == ROL) ? q[WIDTH-1] : q[0];
  end
`endif
endmodule
